simon_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one top_simon encryption core (128-bit block, 128-bit key) between NUM_REQ requesters. It accepts one request at a time and latches its plaintext and key. It then pulses the core's start, waits for the core's valid, and returns the ciphertext on a shared response channel tagged with the requester ID. It sits between the requester-side logic and the top_simon instance.

---
 rtl/simon_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_simon_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_arbiter.sv
// simon_arbiter: round-robin arbiter that shares one Simon128/128 core between NUM_REQ requesters.
// Latency: accept edge to first rsp_valid_o cycle is 2 + core latency (start pulse to core_valid_i).
// Backpressure: one transaction in flight; the response holds until rsp_ready_i, and no new grant is made until then.
//
// Ports:
//   req_valid_i/req_ready_o/req_pt_i/req_key_i : per-requester request channel (128-bit slices per requester)
//   rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_ct_o/rsp_err_o : shared response channel, tagged with requester ID
//   core_start_o/core_pt_o/core_k0_o/core_valid_i/core_ct_i : connection to the top_simon core
//   busy_o : high whenever a transaction is in flight
//
// Optional build macro SIMON_ARB_TIMEOUT_EN: adds a WAIT-state watchdog of TIMEOUT_CYCLES cycles that
// returns an error response (rsp_err_o=1, rsp_ct_o=0). Without it WAIT holds until the core answers.
module simon_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*128-1:0] req_pt_i,
  input  logic [NUM_REQ*128-1:0] req_key_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [127:0]           rsp_ct_o,
  output logic                   rsp_err_o,
  output logic                   core_start_o,
  output logic [127:0]           core_pt_o,
  output logic [127:0]           core_k0_o,
  input  logic                   core_valid_i,
  input  logic [127:0]           core_ct_i,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [127:0]     pt_q, pt_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     ct_q, ct_d;

`ifdef SIMON_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Round-robin pick: the lowest requester above last_q wins; if none,
  // wrap around to the lowest requester overall.
  logic            hi_found, lo_found, grant_vld;
  logic [ID_W-1:0] hi_id, lo_id, grant_id;
  logic [127:0]    sel_pt, sel_key;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid_i[i]) begin
        if (!hi_found && (ID_W'(i) > last_q)) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_id    = ID_W'(i);
        end
      end
    end
    grant_vld = lo_found;
    grant_id  = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    sel_pt  = '0;
    sel_key = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_pt  = req_pt_i[i*128 +: 128];
        sel_key = req_key_i[i*128 +: 128];
      end
    end
  end

  // State register and datapath holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      pt_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
`ifdef SIMON_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
`ifdef SIMON_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    pt_d    = pt_q;
    key_d   = key_q;
    ct_d    = ct_q;
`ifdef SIMON_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          pt_d    = sel_pt;
          key_d   = sel_key;
          id_d    = grant_id;
          state_d = S_START;
        end
      end
      S_START: begin
`ifdef SIMON_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A core result on the watchdog's final cycle still takes priority.
        if (core_valid_i) begin
          ct_d    = core_ct_i;
`ifdef SIMON_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef SIMON_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          ct_d    = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          last_d  = id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. req_ready_o is gated by rst_n so that nothing is accepted while
  // reset is asserted, even though the state already reads IDLE.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = rst_n && (state_q == S_IDLE) && grant_vld && (grant_id == ID_W'(i));
    end
    core_start_o = (state_q == S_START);
    rsp_valid_o  = (state_q == S_RESP);
    busy_o       = (state_q != S_IDLE);
  end

  assign rsp_id_o  = id_q;
  assign rsp_ct_o  = ct_q;
  assign core_pt_o = pt_q;
  assign core_k0_o = key_q;

`ifdef SIMON_ARB_TIMEOUT_EN
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_simon_arbiter.sv
// tb_simon_arbiter: directed bench for simon_arbiter with a behavioural Simon128/128 core model.
// Latency: core model answers core_lat cycles after the start pulse.
// Backpressure: rsp_ready_i driven explicitly per test.
module tb_simon_arbiter;

  localparam int LAT_DEF = 3;
  localparam logic [127:0] VEC_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] VEC_PT  = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] VEC_CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid_i;
  logic [3:0]   req_ready_o;
  logic [511:0] req_pt_i;
  logic [511:0] req_key_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [1:0]   rsp_id_o;
  logic [127:0] rsp_ct_o;
  logic         rsp_err_o;
  logic         core_start_o;
  logic [127:0] core_pt_o;
  logic [127:0] core_k0_o;
  logic         core_valid_i;
  logic [127:0] core_ct_i;
  logic         busy_o;

  always #5 clk = ~clk;

  simon_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_pt_i     (req_pt_i),
    .req_key_i    (req_key_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_ct_o     (rsp_ct_o),
    .rsp_err_o    (rsp_err_o),
    .core_start_o (core_start_o),
    .core_pt_o    (core_pt_o),
    .core_k0_o    (core_k0_o),
    .core_valid_i (core_valid_i),
    .core_ct_i    (core_ct_i),
    .busy_o       (busy_o)
  );

  // ---------------- Simon128/128 reference ----------------
  function automatic logic [63:0] ror64(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] v, input int s);
    return (v << s) | (v >> (64 - s));
  endfunction

  function automatic logic [127:0] simon(input logic [127:0] pt, input logic [127:0] key);
    logic [63:0] k [68];
    logic [63:0] x, y, t, z;
    z    = 64'h7369f885192c0ef5;  // z2 sequence, bit i = z2[i]
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      t = ror64(k[i+1], 3);
      t = t ^ ror64(t, 1);
      k[i+2] = ~k[i] ^ t ^ 64'd3 ^ {63'd0, z[i % 62]};
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      t = x;
      x = y ^ (rol64(x, 1) & rol64(x, 8)) ^ rol64(x, 2) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // ---------------- core model ----------------
  int           core_lat = LAT_DEF;
  bit           core_dis = 1'b0;
  logic         spur_v   = 1'b0;
  logic         model_v  = 1'b0;
  logic [127:0] model_ct = '0;
  bit           pend     = 1'b0;
  int           pend_cnt = 0;
  logic [127:0] pend_ct  = '0;

  assign core_valid_i = model_v | spur_v;
  assign core_ct_i    = spur_v ? 128'hdeadbeef_deadbeef_deadbeef_deadbeef : model_ct;

  always @(negedge clk) begin
    model_v = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (pend_cnt <= 1) begin
          model_v  = 1'b1;
          model_ct = pend_ct;
          pend     = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (core_start_o && !core_dis) begin
        pend     = 1'b1;
        pend_cnt = core_lat;
        pend_ct  = simon(core_pt_o, core_k0_o);
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] pt_of(input int n);
    return req_pt_i[n*128 +: 128];
  endfunction

  function automatic logic [127:0] key_of(input int n);
    return req_key_i[n*128 +: 128];
  endfunction

  // Called at a negedge with the request already driven: checks the grant,
  // the start pulse, the latency and the response, then accepts it.
  task automatic serve(input string tag, input logic [3:0] exp_rdy, input int exp_id,
                       input logic [127:0] exp_ct, input int exp_lat, input bit drop);
    int lat;
    #1 check({tag, "_grant"}, req_ready_o, exp_rdy);
    tick();
    if (drop) req_valid_i[exp_id] = 1'b0;
    #1;
    check({tag, "_start"}, core_start_o, 1'b1);
    check({tag, "_rdy_busy"}, req_ready_o, 4'b0000);
    lat = 1;
    while (!rsp_valid_o && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_id"}, rsp_id_o, exp_id);
    check({tag, "_ct"}, rsp_ct_o, exp_ct);
    check({tag, "_err"}, rsp_err_o, 1'b0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    #1 check({tag, "_rsp_drop"}, rsp_valid_o, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int busy_cnt;
    int order [5];
    logic [3:0] rdy;
    order = '{0, 1, 2, 3, 0};

    rst_n       = 1'b1;
    req_valid_i = '0;
    req_pt_i    = '0;
    req_key_i   = '0;
    rsp_ready_i = 1'b0;

    // Reset with every requester asserting: nothing may be accepted.
    tick();
    req_valid_i = 4'hF;
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready_o, 4'b0000);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_start", core_start_o, 1'b0);
    check("rst_rsp_ct", rsp_ct_o, 128'd0);
    check("rst_core_pt", core_pt_o, 128'd0);
    check("rst_core_k0", core_k0_o, 128'd0);
    check("rst_rsp_id", rsp_id_o, 2'd0);
    check("rst_rsp_err", rsp_err_o, 1'b0);
    repeat (3) tick();
    req_valid_i = '0;
    rst_n = 1'b1;

    // Single request: published Simon128/128 vector on requester 1.
    tick();
    req_pt_i[1*128 +: 128]  = VEC_PT;
    req_key_i[1*128 +: 128] = VEC_KEY;
    req_valid_i = 4'b0010;
    serve("single", 4'b0010, 1, VEC_CT, 2 + LAT_DEF, 1'b1);

    // Round robin from reset with all four requesters held valid.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_pt_i[i*128 +: 128]  = 128'h0011_2233_4455_6677_8899_aabb_ccdd_ee00 + 128'(i * 17);
      req_key_i[i*128 +: 128] = 128'h1357_9bdf_0246_8ace_fdb9_7531_eca8_6420 ^ 128'(i << 8);
    end
    req_valid_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      rdy = 4'b0001 << order[k];
      serve($sformatf("rr%0d", k), rdy, order[k],
            simon(pt_of(order[k]), key_of(order[k])), 2 + LAT_DEF, 1'b0);
    end
    req_valid_i = '0;

    // Backpressure: response held for 20 cycles while another request waits.
    req_valid_i = 4'b0100;
    #1 check("bp_grant", req_ready_o, 4'b0100);
    tick();
    req_valid_i = 4'b0000;
    lat = 1;
    while (!rsp_valid_o && lat < 200) begin
      tick();
      lat++;
    end
    check("bp_lat", lat, 2 + LAT_DEF);
    req_valid_i = 4'b1001;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("bp_valid", rsp_valid_o, 1'b1);
      check("bp_id", rsp_id_o, 2'd2);
      check("bp_ct", rsp_ct_o, simon(pt_of(2), key_of(2)));
      check("bp_no_ready", req_ready_o, 4'b0000);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    #1 check("bp_rsp_drop", rsp_valid_o, 1'b0);
    serve("bp_next", 4'b1000, 3, simon(pt_of(3), key_of(3)), 2 + LAT_DEF, 1'b1);
    req_valid_i = '0;

    // Reset five cycles after the start pulse: silent abort, priority back to 0.
    core_lat = 20;
    req_valid_i = 4'b0010;
    #1 check("mid_grant", req_ready_o, 4'b0010);
    tick();
    req_valid_i = 4'b0000;
    #1 check("mid_start", core_start_o, 1'b1);
    repeat (5) tick();
    req_valid_i = 4'b0011;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_ready", req_ready_o, 4'b0000);
    check("mid_rst_core_pt", core_pt_o, 128'd0);
    check("mid_rst_core_k0", core_k0_o, 128'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("mid_rst_hold", rsp_valid_o, 1'b0);
    end
    rst_n = 1'b1;
    core_lat = LAT_DEF;
    serve("post_rst", 4'b0001, 0, simon(pt_of(0), key_of(0)), 2 + LAT_DEF, 1'b1);
    req_valid_i = '0;

    // Stray core_valid_i in IDLE must not create a response.
    spur_v = 1'b1;
    tick();
    spur_v = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("spur_no_rsp", rsp_valid_o, 1'b0);
      check("spur_idle", busy_o, 1'b0);
    end
    req_valid_i = 4'b0100;
    serve("after_spur", 4'b0100, 2, simon(pt_of(2), key_of(2)), 2 + LAT_DEF, 1'b1);

    // Core never answers.
    core_dis = 1'b1;
    req_valid_i = 4'b1000;
`ifdef SIMON_ARB_TIMEOUT_EN
    #1 check("to_grant", req_ready_o, 4'b1000);
    tick();
    req_valid_i = 4'b0000;
    lat = 1;
    while (!rsp_valid_o && lat < 200) begin
      tick();
      lat++;
    end
    check("to_lat", lat, 10);
    check("to_err", rsp_err_o, 1'b1);
    check("to_ct", rsp_ct_o, 128'd0);
    check("to_id", rsp_id_o, 2'd3);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    #1 check("to_rsp_drop", rsp_valid_o, 1'b0);
`else
    #1 check("hang_grant", req_ready_o, 4'b1000);
    tick();
    req_valid_i = 4'b0000;
    busy_cnt = 0;
    repeat (1000) begin
      tick();
      if (busy_o && !rsp_valid_o) busy_cnt++;
    end
    check("hang_busy_cycles", busy_cnt, 1000);
    do_reset();
    #1 check("hang_cleared", busy_o, 1'b0);
`endif
    core_dis = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1, "time limit");
  end

endmodule
